// File: rtl/regfile_pkg.sv
// Shared types and constants for the LEGv8 register file.
// byte_merge describes the byte-enable update rule for a 64-bit word.
package regfile_pkg;

  localparam int unsigned WORD_W   = 64;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned XZR_IDX  = 31;
  localparam int unsigned BYTES_W  = WORD_W / 8;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BYTES_W-1:0] bmask_t;

  // Bytes whose mask bit is set come from newWord; the others keep oldWord.
  function automatic word_t byte_merge(input word_t oldWord, input word_t newWord,
                                       input bmask_t mask);
    word_t res;
    res = oldWord;
    for (int k = 0; k < int'(BYTES_W); k++) begin
      if (mask[k]) res[8*k +: 8] = newWord[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/D_FF.sv
// Single-bit D flip-flop with synchronous active-high reset.
module D_FF (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end

endmodule

// File: rtl/mux2_1.sv
// Single-bit 2:1 multiplexer cell.
module mux2_1 (
  input  logic sel,
  input  logic in0,
  input  logic in1,
  output logic out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/regfile_entry.sv
// One storage word of the register file: per bit a hold/load mux feeding a flop.
// Byte enable k selects load for bits [8k+7:8k]; reset inside the flop wins.
module regfile_entry
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH/8-1:0] byteEn,
  input  logic [WIDTH-1:0]   writeData,
  output logic [WIDTH-1:0]   q
);

  logic [WIDTH-1:0] dNext;

  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    mux2_1 uMux (
      .sel (byteEn[i/8]),
      .in0 (q[i]),
      .in1 (writeData[i]),
      .out (dNext[i])
    );

    D_FF uFf (
      .clk   (clk),
      .reset (reset),
      .d     (dNext[i]),
      .q     (q[i])
    );
  end

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file: one byte-enabled write port, two combinational read
// ports, optional same-cycle write forwarding and a hard-wired zero register.
module register_file_param
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = WORD_W,
  parameter int unsigned DEPTH    = NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned ZERO_REG = XZR_IDX,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               writeEnable,
  input  logic [ADDR_W-1:0]  writeAddr,
  input  logic [WIDTH-1:0]   writeData,
  input  logic [WIDTH/8-1:0] byteEn,
  input  logic [ADDR_W-1:0]  readAddrA,
  input  logic [ADDR_W-1:0]  readAddrB,
  output logic [WIDTH-1:0]   readDataA,
  output logic [WIDTH-1:0]   readDataB
);

  localparam int unsigned NB      = WIDTH / 8;
  localparam bit          HasZero = (ZERO_REG < DEPTH);

  logic [WIDTH-1:0] entryQ [DEPTH];
  logic [WIDTH-1:0] storedA, storedB;
  logic             writeToZero;
  logic             hitA, hitB;

  function automatic logic [WIDTH-1:0] mergeBytes(input logic [WIDTH-1:0] oldWord,
                                                  input logic [WIDTH-1:0] newWord,
                                                  input logic [NB-1:0]    mask);
    logic [WIDTH-1:0] res;
    res = oldWord;
    for (int k = 0; k < int'(NB); k++) begin
      if (mask[k]) res[8*k +: 8] = newWord[8*k +: 8];
    end
    return res;
  endfunction

  assign writeToZero = HasZero && (writeAddr == ADDR_W'(ZERO_REG));

  // Decoder: each entry sees byteEn only when it is the write target.
  for (genvar e = 0; e < DEPTH; e++) begin : gEntry
    if (ZERO_REG == unsigned'(e)) begin : gZero
      assign entryQ[e] = '0;
    end else begin : gReg
      logic [NB-1:0] entryEn;
      assign entryEn = (writeEnable && (writeAddr == ADDR_W'(e))) ? byteEn : '0;

      regfile_entry #(
        .WIDTH (WIDTH)
      ) uEntry (
        .clk       (clk),
        .reset     (reset),
        .byteEn    (entryEn),
        .writeData (writeData),
        .q         (entryQ[e])
      );
    end
  end

  assign storedA = entryQ[readAddrA];
  assign storedB = entryQ[readAddrB];

  // Forwarding is suppressed during reset and for the zero register.
  assign hitA = BYPASS && !reset && writeEnable && !writeToZero && (readAddrA == writeAddr);
  assign hitB = BYPASS && !reset && writeEnable && !writeToZero && (readAddrB == writeAddr);

  always_comb begin
    readDataA = storedA;
    readDataB = storedB;
    if (hitA) readDataA = mergeBytes(storedA, writeData, byteEn);
    if (hitB) readDataB = mergeBytes(storedB, writeData, byteEn);
  end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: a forwarding and a non-forwarding instance share stimulus.
module tb_register_file_param;
  import regfile_pkg::*;

  logic       clk = 1'b0;
  logic       reset, writeEnable;
  logic [4:0] writeAddr, readAddrA, readAddrB;
  word_t      writeData;
  logic [7:0] byteEn;
  word_t      rdA, rdB, rdA0, rdB0;

  always #5 clk = ~clk;

  register_file_param #(.BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .writeEnable(writeEnable), .writeAddr(writeAddr),
    .writeData(writeData), .byteEn(byteEn), .readAddrA(readAddrA), .readAddrB(readAddrB),
    .readDataA(rdA), .readDataB(rdB)
  );

  register_file_param #(.BYPASS(1'b0)) dutNb (
    .clk(clk), .reset(reset), .writeEnable(writeEnable), .writeAddr(writeAddr),
    .writeData(writeData), .byteEn(byteEn), .readAddrA(readAddrA), .readAddrB(readAddrB),
    .readDataA(rdA0), .readDataB(rdB0)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       we;
    logic [4:0] wa;
    word_t      wd;
    logic [7:0] be;
    logic [4:0] ra;
    logic [4:0] rb;
    word_t      eA, eB, eA0, eB0;
  } vec_t;

  typedef struct {
    string name;
    word_t eA, eB, eA0, eB0;
  } exp_t;

  exp_t  sbq[$];
  vec_t  vecs[17];
  word_t model[32];
  int    nChecks = 0;
  int    nFail   = 0;

  task automatic check(input string name, input word_t got, input word_t expv);
    nChecks++;
    if (got !== expv) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  // Drive just after a rising edge, compare at the falling edge, then let the edge commit.
  task automatic step(input vec_t v);
    exp_t x;
    reset = v.rst; writeEnable = v.we; writeAddr = v.wa; writeData = v.wd;
    byteEn = v.be; readAddrA = v.ra; readAddrB = v.rb;
    sbq.push_back('{v.name, v.eA, v.eB, v.eA0, v.eB0});
    @(negedge clk);
    if (sbq.size() == 0) begin
      nChecks++; nFail++;
      $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", v.name);
    end else begin
      x = sbq.pop_front();
      check({x.name, ".bypA"}, rdA, x.eA);
      check({x.name, ".bypB"}, rdB, x.eB);
      check({x.name, ".nbA"}, rdA0, x.eA0);
      check({x.name, ".nbB"}, rdB0, x.eB0);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic word_t mrg(input word_t oldW, input word_t newW, input logic [7:0] be);
    word_t r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = be[k] ? newW[8*k +: 8] : oldW[8*k +: 8];
    return r;
  endfunction

  function automatic word_t mdlRead(input logic [4:0] addr, input bit bp, input logic rst,
                                    input logic we, input logic [4:0] wa, input word_t wd,
                                    input logic [7:0] be);
    if (addr == 5'd31) return '0;
    if (bp && !rst && we && addr == wa) return mrg(model[addr], wd, be);
    return model[addr];
  endfunction

  task automatic stepModel(input string name, input logic we, input logic [4:0] wa,
                           input word_t wd, input logic [7:0] be, input logic [4:0] ra,
                           input logic [4:0] rb);
    vec_t v;
    v.name = name; v.rst = 1'b0; v.we = we; v.wa = wa; v.wd = wd; v.be = be;
    v.ra = ra; v.rb = rb;
    v.eA  = mdlRead(ra, 1'b1, 1'b0, we, wa, wd, be);
    v.eB  = mdlRead(rb, 1'b1, 1'b0, we, wa, wd, be);
    v.eA0 = mdlRead(ra, 1'b0, 1'b0, we, wa, wd, be);
    v.eB0 = mdlRead(rb, 1'b0, 1'b0, we, wa, wd, be);
    step(v);
    if (we && wa != 5'd31) model[wa] = mrg(model[wa], wd, be);
  endtask

  initial begin
    //          name      rst   we    wa     wd                     be     ra     rb
    //          bypass A / B                                 no-bypass A / B
    vecs[0]  = '{"rd0",   1'b0, 1'b0, 5'd0,  64'd0,                 8'h00, 5'd0,  5'd30,
                 64'd0, 64'd0, 64'd0, 64'd0};
    vecs[1]  = '{"wr5",   1'b0, 1'b1, 5'd5,  64'h0123_4567_89AB_CDEF, 8'hFF, 5'd5, 5'd0,
                 64'h0123_4567_89AB_CDEF, 64'd0, 64'd0, 64'd0};
    vecs[2]  = '{"rd5",   1'b0, 1'b0, 5'd0,  64'd0,                 8'h00, 5'd5,  5'd6,
                 64'h0123_4567_89AB_CDEF, 64'd0, 64'h0123_4567_89AB_CDEF, 64'd0};
    vecs[3]  = '{"part5", 1'b0, 1'b1, 5'd5,  64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 5'd5, 5'd5,
                 64'h0123_4567_FFFF_FFFF, 64'h0123_4567_FFFF_FFFF,
                 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vecs[4]  = '{"rd5b",  1'b0, 1'b0, 5'd0,  64'd0,                 8'h00, 5'd5,  5'd4,
                 64'h0123_4567_FFFF_FFFF, 64'd0, 64'h0123_4567_FFFF_FFFF, 64'd0};
    vecs[5]  = '{"byp7",  1'b0, 1'b1, 5'd7,  64'd405,               8'hFF, 5'd7,  5'd7,
                 64'd405, 64'd405, 64'd0, 64'd0};
    vecs[6]  = '{"rd7",   1'b0, 1'b0, 5'd0,  64'd0,                 8'h00, 5'd7,  5'd5,
                 64'd405, 64'h0123_4567_FFFF_FFFF, 64'd405, 64'h0123_4567_FFFF_FFFF};
    vecs[7]  = '{"xzr",   1'b0, 1'b1, 5'd31, 64'd32,                8'hFF, 5'd31, 5'd31,
                 64'd0, 64'd0, 64'd0, 64'd0};
    vecs[8]  = '{"wr3",   1'b0, 1'b1, 5'd3,  64'hAA,                8'hFF, 5'd31, 5'd7,
                 64'd0, 64'd405, 64'd0, 64'd405};
    vecs[9]  = '{"rstWr", 1'b1, 1'b1, 5'd3,  64'd128,               8'hFF, 5'd3,  5'd5,
                 64'hAA, 64'h0123_4567_FFFF_FFFF, 64'hAA, 64'h0123_4567_FFFF_FFFF};
    vecs[10] = '{"post",  1'b0, 1'b0, 5'd0,  64'd0,                 8'h00, 5'd3,  5'd5,
                 64'd0, 64'd0, 64'd0, 64'd0};
    vecs[11] = '{"be0",   1'b0, 1'b1, 5'd2,  64'hDEAD,              8'h00, 5'd2,  5'd2,
                 64'd0, 64'd0, 64'd0, 64'd0};
    vecs[12] = '{"rdbe0", 1'b0, 1'b0, 5'd0,  64'd0,                 8'h00, 5'd2,  5'd31,
                 64'd0, 64'd0, 64'd0, 64'd0};
    vecs[13] = '{"bA5",   1'b0, 1'b1, 5'd2,  64'h1122_3344_5566_7788, 8'hA5, 5'd2, 5'd1,
                 64'h1100_3300_0066_0088, 64'd0, 64'd0, 64'd0};
    vecs[14] = '{"rd2",   1'b0, 1'b0, 5'd0,  64'd0,                 8'h00, 5'd2,  5'd1,
                 64'h1100_3300_0066_0088, 64'd0, 64'h1100_3300_0066_0088, 64'd0};
    vecs[15] = '{"mixed", 1'b0, 1'b1, 5'd1,  64'hFF,                8'h01, 5'd2,  5'd1,
                 64'h1100_3300_0066_0088, 64'hFF, 64'h1100_3300_0066_0088, 64'd0};
    vecs[16] = '{"rd1",   1'b0, 1'b0, 5'd0,  64'd0,                 8'h00, 5'd1,  5'd2,
                 64'hFF, 64'h1100_3300_0066_0088, 64'hFF, 64'h1100_3300_0066_0088};

    reset = 1'b1; writeEnable = 1'b0; writeAddr = '0; writeData = '0; byteEn = '0;
    readAddrA = '0; readAddrB = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) step(vecs[i]);

    // Fresh reset, then fill every entry (31 included) with index*3 and sweep both ports.
    reset = 1'b1; writeEnable = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int i = 0; i < 32; i++)
      stepModel($sformatf("fill%0d", i), 1'b1, 5'(i), word_t'(i * 3), 8'hFF, 5'(i),
                5'((i + 1) % 32));
    for (int i = 0; i < 32; i++)
      stepModel($sformatf("sweep%0d", i), 1'b0, 5'd0, 64'd0, 8'h00, 5'(i), 5'(31 - i));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
